// File: rtl/i2c_slave_responder.sv
// I2C target that ACKs one 7-bit address and serves reads/writes against a small
// register file through an auto-incrementing pointer. scl/sda are oversampled on i2c_clk.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         DEPTH      = 8,
  parameter int         AW         = $clog2(DEPTH)
) (
  input  logic          i2c_clk,
  input  logic          preset_n,
  input  logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] ptr
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t        state, state_n;
  logic          scl_m, scl_s, scl_d;
  logic          sda_m, sda_s, sda_d;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [6:0]    shift, shift_n;
  logic          rw, rw_n;
  logic          first_byte, first_byte_n;
  logic          sda_oe, sda_oe_n;
  logic          busy_n;
  logic [AW-1:0] ptr_n;
  logic          mem_we;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_word;
  logic [7:0]    mem [DEPTH];
  logic          scl_rise, scl_fall, start_det, stop_det;

  // Open drain: only ever pull low or let go.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;
  assign rx_byte   = {shift, sda_s};
  assign rd_word   = mem[ptr];

  // Synchronizers idle high so reset release does not fake a bus edge on sda.
  always_ff @(posedge i2c_clk) begin
    if (!preset_n) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  always_ff @(posedge i2c_clk) begin
    if (!preset_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 7'd0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      ptr        <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      rw         <= rw_n;
      first_byte <= first_byte_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      ptr        <= ptr_n;
      wr_valid   <= mem_we;
      if (mem_we) begin
        mem[ptr] <= rx_byte;
        wr_addr  <= ptr;
        wr_data  <= rx_byte;
      end
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    rw_n         = rw;
    first_byte_n = first_byte;
    sda_oe_n     = sda_oe;
    busy_n       = busy;
    ptr_n        = ptr;
    mem_we       = 1'b0;
    // Bus conditions override whatever byte is in flight; partial bytes are dropped.
    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_n   = rx_byte[6:0];
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = 4'd0;
              if (shift == SLAVE_ADDR) begin
                state_n = ADDR_ACK;
                rw_n    = sda_s;
                busy_n  = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        // First falling edge starts the ACK pull-down, the second ends it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (rw) begin
              shift_n   = rd_word[6:0];
              sda_oe_n  = ~rd_word[7];
              bit_cnt_n = 4'd0;
              state_n   = RD_BYTE;
            end else begin
              sda_oe_n     = 1'b0;
              first_byte_n = 1'b1;
              bit_cnt_n    = 4'd0;
              state_n      = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_n   = rx_byte[6:0];
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = 4'd0;
              state_n   = WR_ACK;
              if (first_byte) begin
                ptr_n        = rx_byte[AW-1:0];
                first_byte_n = 1'b0;
              end else begin
                mem_we = 1'b1;
                ptr_n  = ptr + 1'b1;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = WR_BYTE;
            end
          end
        end
        // shift holds the bits still to be sent, next one at [6].
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              sda_oe_n = 1'b0;
              state_n  = RD_ACK;
            end else begin
              sda_oe_n  = ~shift[6];
              shift_n   = {shift[5:0], 1'b0};
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        // bit_cnt==8 marks "master ACKed, next byte goes out on the coming fall".
        RD_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr + 1'b1;
            if (sda_s) state_n = IGNORE;
            else       bit_cnt_n = 4'd8;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            shift_n   = rd_word[6:0];
            sda_oe_n  = ~rd_word[7];
            bit_cnt_n = 4'd0;
            state_n   = RD_BYTE;
          end
        end
        IGNORE:  sda_oe_n = 1'b0;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, table of write transactions,
// hand sequences for reads/abort/reset, random transactions against a register-file model.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam logic [6:0] SLAVE_ADDR = 7'h3C;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int W     = AW + 8;
  localparam int Q     = 5;

  logic          i2c_clk;
  logic          preset_n;
  logic          scl;
  logic          m_sda_low;
  wire           sda;
  logic          busy;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] ptr;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_responder #(
    .SLAVE_ADDR(SLAVE_ADDR),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) dut (
    .i2c_clk (i2c_clk),
    .preset_n(preset_n),
    .scl     (scl),
    .sda     (sda),
    .busy    (busy),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ptr     (ptr)
  );

  // clock / reset
  initial i2c_clk = 1'b0;
  always #5 i2c_clk = ~i2c_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required end of test");
    $fatal(1);
  end

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  m_mem [DEPTH];
  int          m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // every register write must match the next expected (addr,data) event
  always @(negedge i2c_clk) begin
    if (preset_n && wr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_event_unexpected: got 0x%0h required none", {wr_addr, wr_data});
      end else begin
        check("wr_event", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks (master side); everything moves on negedge
  task automatic wait_q();
    repeat (Q) @(negedge i2c_clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; wait_q();
    scl = 1'b1;     wait_q(); wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    b = sda;          wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    acked = ~b;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d, output logic released);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    released = sda;
    send_bit(nack);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
  endfunction

  // Write transfer: first byte after the address is the pointer, rest are data.
  task automatic write_txn(input logic [6:0] addr, input logic [3:0][7:0] d, input int n,
                           output logic addr_acked);
    logic match, acked;
    match = (addr == SLAVE_ADDR);
    bus_start();
    send_byte({addr, 1'b0}, addr_acked);
    check("addr_ack", 32'(addr_acked), 32'(match));
    check("busy_after_addr", 32'(busy), 32'(match));
    for (int i = 0; i < n; i++) begin
      if (match) begin
        if (i == 0) begin
          m_ptr = int'(d[i]) % DEPTH;
        end else begin
          exp_q.push_back({AW'(m_ptr), d[i]});
          m_mem[m_ptr] = d[i];
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
      send_byte(d[i], acked);
      check("data_ack", 32'(acked), 32'(match));
    end
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check("ptr_after_write", 32'(ptr), 32'(m_ptr));
  endtask

  // Read transfer, optionally preceded by a pointer write and repeated START.
  task automatic read_txn(input logic set_ptr, input logic [7:0] pbyte, input int n);
    logic       acked, rel;
    logic [7:0] got, exp;
    bus_start();
    if (set_ptr) begin
      send_byte({SLAVE_ADDR, 1'b0}, acked);
      check("rd_wr_addr_ack", 32'(acked), 32'd1);
      m_ptr = int'(pbyte) % DEPTH;
      send_byte(pbyte, acked);
      check("rd_ptr_ack", 32'(acked), 32'd1);
      bus_start();
    end
    send_byte({SLAVE_ADDR, 1'b1}, acked);
    check("rd_addr_ack", 32'(acked), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp = m_mem[m_ptr];
      m_ptr = (m_ptr + 1) % DEPTH;
      recv_byte(i == n - 1, got, rel);
      check("rd_data", 32'(got), 32'(exp));
      check("rd_ack_slot_released", 32'(rel), 32'd1);
    end
    bus_stop();
    check("busy_after_rd_stop", 32'(busy), 32'd0);
    check("ptr_after_read", 32'(ptr), 32'(m_ptr));
  endtask

  typedef struct packed {
    logic [6:0]      addr;
    logic [3:0][7:0] d;
    logic [2:0]      n;
    logic            exp_ack;
    logic [AW-1:0]   exp_ptr;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] a, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [2:0] n, input logic ack,
                              input logic [AW-1:0] p);
    vec_t v;
    v.addr    = a;
    v.d       = {8'h00, b2, b1, b0};
    v.n       = n;
    v.exp_ack = ack;
    v.exp_ptr = p;
    return v;
  endfunction

  vec_t            tbl [6];
  logic            acked, b;
  logic [6:0]      ra;
  logic [3:0][7:0] rd;

  initial begin
    tbl[0] = mk(7'h3C, 8'h02, 8'hA5, 8'h5A, 3'd3, 1'b1, 3'd4);
    tbl[1] = mk(7'h50, 8'h11, 8'h00, 8'h00, 3'd1, 1'b0, 3'd4);
    tbl[2] = mk(7'h3C, 8'h07, 8'h11, 8'h22, 3'd3, 1'b1, 3'd1);
    tbl[3] = mk(7'h3C, 8'h0D, 8'h33, 8'h44, 3'd3, 1'b1, 3'd7);
    tbl[4] = mk(7'h3D, 8'h01, 8'hFF, 8'h00, 3'd2, 1'b0, 3'd7);
    tbl[5] = mk(7'h3C, 8'h05, 8'h00, 8'h00, 3'd1, 1'b1, 3'd5);

    preset_n  = 1'b0;
    scl       = 1'b1;
    m_sda_low = 1'b0;
    model_reset();
    repeat (4) @(negedge i2c_clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_valid", 32'(wr_valid), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_ptr", 32'(ptr), 32'd0);
    check("reset_sda", 32'(sda), 32'd1);
    preset_n = 1'b1;
    repeat (4) @(negedge i2c_clk);

    for (int i = 0; i < 6; i++) begin
      write_txn(tbl[i].addr, tbl[i].d, int'(tbl[i].n), acked);
      check("tbl_addr_ack", 32'(acked), 32'(tbl[i].exp_ack));
      check("tbl_ptr", 32'(ptr), 32'(tbl[i].exp_ptr));
    end

    // read back with repeated START, then across the wrap, then from the kept pointer
    read_txn(1'b1, 8'h02, 2);
    check("rd_plan_ptr", 32'(ptr), 32'd4);
    read_txn(1'b1, 8'h07, 2);
    check("rd_wrap_ptr", 32'(ptr), 32'd1);
    read_txn(1'b0, 8'h00, 2);

    // abort a data byte after 5 bits
    bus_start();
    send_byte({SLAVE_ADDR, 1'b0}, acked);
    send_byte(8'h04, acked);
    m_ptr = 4;
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    bus_stop();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ptr", 32'(ptr), 32'd4);
    bus_start();
    send_byte({SLAVE_ADDR, 1'b0}, acked);
    check("after_abort_ack", 32'(acked), 32'd1);
    bus_stop();
    check("after_abort_ptr", 32'(ptr), 32'd4);

    // random transactions against the model
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
        for (int j = 0; j < 4; j++) rd[j] = 8'($urandom);
        write_txn(ra, rd, $urandom_range(1, 4), acked);
      end else begin
        read_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3));
      end
    end

    // reset while the responder pulls a 0 data bit (0xA5 bit 6)
    write_txn(SLAVE_ADDR, {8'h00, 8'h00, 8'hA5, 8'h02}, 2, acked);
    bus_start();
    send_byte({SLAVE_ADDR, 1'b0}, acked);
    send_byte(8'h02, acked);
    bus_start();
    send_byte({SLAVE_ADDR, 1'b1}, acked);
    recv_bit(b);
    check("mid_read_bit7", 32'(b), 32'd1);
    check("mid_read_driving_low", 32'(sda), 32'd0);
    preset_n = 1'b0;
    @(negedge i2c_clk);
    check("rst_sda_released", 32'(sda), 32'd1);
    check("rst_ptr", 32'(ptr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    preset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge i2c_clk);
    bus_stop();
    read_txn(1'b1, 8'h02, 2);
    read_txn(1'b0, 8'h00, 3);

    repeat (10) @(negedge i2c_clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
